// File: rtl/otter_id_ex_stage.sv
// OTTER ID/EX pipeline register: hazard stall, bubble/flush injection and operand forwarding.
// Build option: define OTTER_FWD_EN for MEM/WB forwarding with load-use-only stalls.
module otter_id_ex_stage #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             id_valid,
   input  logic [31:0]      id_pc,
   input  logic [6:0]       id_opcode,
   input  logic [2:0]       id_funct3,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [31:0]      id_rs1_data,
   input  logic [31:0]      id_rs2_data,
   input  logic [31:0]      id_imm,
   input  logic [15:0]      id_ctrl,
   input  logic             ex_flush,
   input  logic             mem_valid,
   input  logic             mem_regWrite,
   input  logic [4:0]       mem_rd,
   input  logic [31:0]      mem_result,
   input  logic             wb_valid,
   input  logic             wb_regWrite,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   output logic             stall,
   output logic             ex_valid,
   output logic [31:0]      ex_pc,
   output logic [31:0]      ex_imm,
   output logic [2:0]       ex_funct3,
   output logic [4:0]       ex_rd,
   output logic [15:0]      ex_ctrl,
   output logic [31:0]      ex_rs1_val,
   output logic [31:0]      ex_rs2_val,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam int         CTRL_REGWRITE = 4;
   localparam int         CTRL_MEMREAD  = 2;

   logic             rs1_used, rs2_used, ex_hit, hazard;
   logic             ex_valid_q, ex_valid_d;
   logic [31:0]      ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
   logic [2:0]       ex_funct3_q, ex_funct3_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic [15:0]      ex_ctrl_q, ex_ctrl_d;
   logic [31:0]      ex_rs1_data_q, ex_rs1_data_d, ex_rs2_data_q, ex_rs2_data_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic use1, input logic use2);
      return (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
   endfunction

   always_comb begin
      rs1_used = (id_opcode != OPC_LUI) && (id_opcode != OPC_AUIPC) && (id_opcode != OPC_JAL);
      rs2_used = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) || (id_opcode == OPC_BRANCH);
   end

   assign ex_hit = src_hit(ex_rd_q, id_rs1, id_rs2, rs1_used, rs2_used);

`ifdef OTTER_FWD_EN
   logic [4:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;

   // Only a load still in EX cannot be forwarded in time.
   assign hazard = id_valid && ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] && ex_hit;

   function automatic logic [31:0] fwd_sel(input logic [4:0] rs, input logic [31:0] raw,
                                           input logic mv, input logic mw, input logic [4:0] mrd,
                                           input logic [31:0] mres, input logic wv, input logic ww,
                                           input logic [4:0] wrd, input logic [31:0] wres);
      if (mv && mw && mrd != 5'd0 && mrd == rs) return mres;
      if (wv && ww && wrd != 5'd0 && wrd == rs) return wres;
      return raw;
   endfunction

   assign ex_rs1_val = fwd_sel(ex_rs1_q, ex_rs1_data_q, mem_valid, mem_regWrite, mem_rd, mem_result,
                               wb_valid, wb_regWrite, wb_rd, wb_data);
   assign ex_rs2_val = fwd_sel(ex_rs2_q, ex_rs2_data_q, mem_valid, mem_regWrite, mem_rd, mem_result,
                               wb_valid, wb_regWrite, wb_rd, wb_data);
`else
   logic mem_hit, wb_hit, unused_results;

   assign mem_hit = src_hit(mem_rd, id_rs1, id_rs2, rs1_used, rs2_used);
   assign wb_hit  = src_hit(wb_rd, id_rs1, id_rs2, rs1_used, rs2_used);
   // Without forwarding any pending writer of a source holds decode until it retires.
   assign hazard  = id_valid && ((ex_valid_q && ex_ctrl_q[CTRL_REGWRITE] && ex_hit) ||
                                 (mem_valid && mem_regWrite && mem_hit) ||
                                 (wb_valid && wb_regWrite && wb_hit));
   assign ex_rs1_val     = ex_rs1_data_q;
   assign ex_rs2_val     = ex_rs2_data_q;
   assign unused_results = ^{mem_result, wb_data};
`endif

   assign stall = hazard && !ex_flush;

   always_comb begin
      ex_valid_d    = id_valid;
      ex_pc_d       = id_pc;
      ex_imm_d      = id_imm;
      ex_funct3_d   = id_funct3;
      ex_rd_d       = id_rd;
      ex_ctrl_d     = id_ctrl;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
`ifdef OTTER_FWD_EN
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
`endif
      stall_count_d = stall_count_q;
      if (ex_flush || hazard) begin
         ex_valid_d = 1'b0;
         ex_ctrl_d  = 16'd0;
      end
      if (stall && stall_count_q != {CNT_W{1'b1}}) stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_imm_q      <= '0;
         ex_funct3_q   <= '0;
         ex_rd_q       <= '0;
         ex_ctrl_q     <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
`ifdef OTTER_FWD_EN
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
`endif
         stall_count_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_imm_q      <= ex_imm_d;
         ex_funct3_q   <= ex_funct3_d;
         ex_rd_q       <= ex_rd_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
`ifdef OTTER_FWD_EN
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
`endif
         stall_count_q <= stall_count_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_imm      = ex_imm_q;
   assign ex_funct3   = ex_funct3_q;
   assign ex_rd       = ex_rd_q;
   assign ex_ctrl     = ex_ctrl_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Randomized scoreboard bench for otter_id_ex_stage; the reference pipeline follows OTTER_FWD_EN
// the same way the design does, and MEM/WB inputs are driven as the bench's own downstream stages.
module tb_otter_id_ex_stage;

   localparam int CW = 4;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [15:0] ctrl;
      logic [31:0] res;
      logic        flushInId;
   } instr_t;

   typedef struct packed {
      logic          isReset;
      logic          stall;
      logic          valid;
      logic [15:0]   ctrl;
      logic [31:0]   pc;
      logic [31:0]   imm;
      logic [2:0]    f3;
      logic [4:0]    rd;
      logic [31:0]   rs1Val;
      logic [31:0]   rs2Val;
      logic [CW-1:0] count;
   } expect_t;

   logic          CLK, RST_N, id_valid, ex_flush;
   logic [31:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [6:0]    id_opcode;
   logic [2:0]    id_funct3;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic [15:0]   id_ctrl;
   logic          mem_valid, mem_regWrite, wb_valid, wb_regWrite;
   logic [4:0]    mem_rd, wb_rd;
   logic [31:0]   mem_result, wb_data;
   logic          stall, ex_valid;
   logic [31:0]   ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
   logic [2:0]    ex_funct3;
   logic [4:0]    ex_rd;
   logic [15:0]   ex_ctrl;
   logic [CW-1:0] stall_count;

   expect_t       expQ[$];
   int            checks = 0;
   int            errors = 0;
   instr_t        exI, memI, wbI;
   logic [CW-1:0] stallCnt;
   bit            lastStall;

   otter_id_ex_stage #(.CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .ex_flush(ex_flush),
      .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_funct3(ex_funct3),
      .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .stall_count(stall_count)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic bit usesRs1(input logic [6:0] opc);
      return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   endfunction

   function automatic bit usesRs2(input logic [6:0] opc);
      return opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH;
   endfunction

   function automatic bit readsReg(input instr_t id, input logic [4:0] r);
      return r != 5'd0 && ((usesRs1(id.opc) && id.rs1 == r) || (usesRs2(id.opc) && id.rs2 == r));
   endfunction

   // A stage writes back when it is real, has regWrite set and targets a non-zero register.
   function automatic bit pendingWrite(input instr_t p, input instr_t id);
      return p.valid && p.ctrl[4] && readsReg(id, p.rd);
   endfunction

   function automatic bit expectHazard(input instr_t id);
`ifdef OTTER_FWD_EN
      return id.valid && exI.valid && exI.ctrl[2] && readsReg(id, exI.rd);
`else
      return id.valid && (pendingWrite(exI, id) || pendingWrite(memI, id) || pendingWrite(wbI, id));
`endif
   endfunction

`ifdef OTTER_FWD_EN
   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] raw);
      if (memI.valid && memI.ctrl[4] && memI.rd != 5'd0 && memI.rd == r) return memI.res;
      if (wbI.valid && wbI.ctrl[4] && wbI.rd != 5'd0 && wbI.rd == r) return wbI.res;
      return raw;
   endfunction
`endif

   function automatic instr_t fixCtrl(input instr_t t);
      instr_t u;
      u = t;
      u.ctrl[4] = !(t.opc == OPC_STORE || t.opc == OPC_BRANCH);
      u.ctrl[2] = (t.opc == OPC_LOAD);
      return u;
   endfunction

   function automatic instr_t randInstr();
      instr_t t;
      case ($urandom_range(0, 8))
         0: t.opc = OPC_LUI;
         1: t.opc = OPC_AUIPC;
         2: t.opc = OPC_JAL;
         3: t.opc = OPC_JALR;
         4: t.opc = OPC_BRANCH;
         5: t.opc = OPC_LOAD;
         6: t.opc = OPC_STORE;
         7: t.opc = OPC_OPIMM;
         default: t.opc = OPC_OP;
      endcase
      t.valid     = ($urandom_range(0, 9) != 0);
      t.pc        = $urandom;
      t.imm       = $urandom;
      t.f3        = 3'($urandom_range(0, 7));
      t.rs1       = 5'($urandom_range(0, 7));
      t.rs2       = 5'($urandom_range(0, 7));
      t.rd        = 5'($urandom_range(0, 7));
      t.d1        = $urandom;
      t.d2        = $urandom;
      t.ctrl      = 16'($urandom);
      t.res       = $urandom;
      t.flushInId = ($urandom_range(0, 11) == 0);
      return fixCtrl(t);
   endfunction

   function automatic instr_t mkInstr(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [31:0] res, input bit fl);
      instr_t t;
      t           = randInstr();
      t.valid     = 1'b1;
      t.opc       = opc;
      t.rs1       = rs1;
      t.rs2       = rs2;
      t.rd        = rd;
      t.res       = res;
      t.flushInId = fl;
      return fixCtrl(t);
   endfunction

   task automatic driveInputs(input instr_t id, input logic v, input logic fl);
      id_valid     = v;
      id_pc        = id.pc;
      id_opcode    = id.opc;
      id_funct3    = id.f3;
      id_rs1       = id.rs1;
      id_rs2       = id.rs2;
      id_rd        = id.rd;
      id_rs1_data  = id.d1;
      id_rs2_data  = id.d2;
      id_imm       = id.imm;
      id_ctrl      = id.ctrl;
      ex_flush     = fl;
      mem_valid    = memI.valid;
      mem_regWrite = memI.ctrl[4];
      mem_rd       = memI.rd;
      mem_result   = memI.res;
      wb_valid     = wbI.valid;
      wb_regWrite  = wbI.ctrl[4];
      wb_rd        = wbI.rd;
      wb_data      = wbI.res;
   endtask

   // Reset drops every in-flight instruction, including anything held in decode.
   task automatic applyReset(input instr_t id, input bit haveId);
      expect_t e;
      @(negedge CLK);
      RST_N    = 1'b0;
      exI      = '0;
      memI     = '0;
      wbI      = '0;
      stallCnt = '0;
      driveInputs(id, haveId ? id.valid : 1'b0, 1'b0);
      e = '0;
      e.isReset = 1'b1;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input instr_t id);
      expect_t e;
      bit haz;
      @(negedge CLK);
      RST_N = 1'b1;
      driveInputs(id, id.valid, id.flushInId);
      haz       = expectHazard(id);
      lastStall = haz && !id.flushInId;
      e         = '0;
      e.stall   = lastStall;
      e.valid   = exI.valid;
      e.ctrl    = exI.ctrl;
      e.pc      = exI.pc;
      e.imm     = exI.imm;
      e.f3      = exI.f3;
      e.rd      = exI.rd;
`ifdef OTTER_FWD_EN
      e.rs1Val  = operand(exI.rs1, exI.d1);
      e.rs2Val  = operand(exI.rs2, exI.d2);
`else
      e.rs1Val  = exI.d1;
      e.rs2Val  = exI.d2;
`endif
      e.count   = stallCnt;
      expQ.push_back(e);
      wbI  = memI;
      memI = exI;
      exI  = id;
      if (haz || id.flushInId) begin
         exI.valid = 1'b0;
         exI.ctrl  = '0;
      end
      if (lastStall && stallCnt != '1) stallCnt = stallCnt + 1'b1;
   endtask

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input expect_t e);
      compareVal("stall", 32'(stall), 32'(e.stall));
      compareVal("ex_valid", 32'(ex_valid), 32'(e.valid));
      compareVal("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
      compareVal("stall_count", 32'(stall_count), 32'(e.count));
      if (e.valid || e.isReset) begin
         compareVal("ex_pc", ex_pc, e.pc);
         compareVal("ex_imm", ex_imm, e.imm);
         compareVal("ex_funct3", 32'(ex_funct3), 32'(e.f3));
         compareVal("ex_rd", 32'(ex_rd), 32'(e.rd));
         compareVal("ex_rs1_val", ex_rs1_val, e.rs1Val);
         compareVal("ex_rs2_val", ex_rs2_val, e.rs2Val);
      end
   endtask

   // Monitor: DUT outputs for a cycle are settled two units after the driving edge.
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         while (expQ.size() > 0) checkOutput(expQ.pop_front());
      end
   end

   // Driver: directed hazard scenarios first, then random traffic with one reset while stalled.
   initial begin
      instr_t dirQ[$];
      instr_t cur;
      bit     held, doReset, resetDone;
      RST_N = 1'b0;
      exI = '0;
      memI = '0;
      wbI = '0;
      stallCnt = '0;
      lastStall = 1'b0;
      cur = '0;
      held = 1'b0;
      doReset = 1'b0;
      resetDone = 1'b0;
      driveInputs(cur, 1'b0, 1'b0);
      dirQ.push_back(mkInstr(OPC_LOAD,  5'd1, 5'd0, 5'd5, 32'h1234, 1'b0));
      dirQ.push_back(mkInstr(OPC_OP,    5'd5, 5'd7, 5'd6, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_OPIMM, 5'd0, 5'd0, 5'd3, 32'hBBBB, 1'b0));
      dirQ.push_back(mkInstr(OPC_OPIMM, 5'd0, 5'd0, 5'd3, 32'hAAAA, 1'b0));
      dirQ.push_back(mkInstr(OPC_OP,    5'd0, 5'd3, 5'd8, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 32'hBBBB, 1'b0));
      dirQ.push_back(mkInstr(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 32'hAAAA, 1'b0));
      dirQ.push_back(mkInstr(OPC_OP,    5'd0, 5'd0, 5'd8, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_LOAD,  5'd0, 5'd0, 5'd9, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_OP,    5'd9, 5'd0, 5'd10, $urandom, 1'b1));
      dirQ.push_back(mkInstr(OPC_LOAD,  5'd1, 5'd0, 5'd5, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_LUI,   5'd5, 5'd5, 5'd5, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_LOAD,  5'd1, 5'd0, 5'd5, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_STORE, 5'd2, 5'd5, 5'd0, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_OPIMM, 5'd0, 5'd0, 5'd5, $urandom, 1'b0));
      dirQ.push_back(mkInstr(OPC_OP,    5'd5, 5'd5, 5'd6, $urandom, 1'b0));
      applyReset(cur, 1'b0);
      for (int cyc = 0; cyc < 500; cyc++) begin
         if (doReset) begin
            applyReset(cur, held);
            held      = 1'b0;
            doReset   = 1'b0;
            resetDone = 1'b1;
         end else begin
            if (!held) begin
               if (dirQ.size() > 0) cur = dirQ.pop_front();
               else cur = randInstr();
            end
            applyStimulus(cur);
            held = lastStall;
            if (!resetDone && cyc > 150 && (lastStall || cyc > 400)) doReset = 1'b1;
         end
      end
      @(negedge CLK);
      #3;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
